// File: rtl/fetch_redirect_ctrl.sv
// Next-PC steering for the fetch stage: a direct-mapped BTB with 2-bit
// counters produces the predicted redirect. Mispredicts resolved in EX
// become flush/pc_branch. A small halt FSM drains fetch before it freezes.
module fetch_redirect_ctrl #(
  parameter int ENTRIES   = 16,
  parameter int IDX_W     = 4,
  parameter int DRAIN_CYC = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpc,
  input  logic        stall_in,
  input  logic        halt_in,
  input  logic        ex_br_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        prediction,
  output logic [31:0] control_pc,
  output logic        flush,
  output logic [31:0] pc_branch,
  output logic        nop,
  output logic        halt_happen,
  output logic [15:0] mispred_cnt
);

  localparam int TAG_W = 30 - IDX_W;
  localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  // BTB storage; kept in flops because reset must clear every entry
  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [31:0]      r_target [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_drain_cnt;
  logic [CNT_W-1:0] w_drain_cnt_next;
  logic [15:0]      r_mispred_cnt;

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic             w_lk_hit;
  logic [IDX_W-1:0] w_upd_idx;
  logic [TAG_W-1:0] w_upd_tag;
  logic             w_upd_hit;
  logic             w_flush;
  logic             w_nop;
  logic             w_unused_bits;

  // Byte-offset bits never select anything; instructions are word aligned
  assign w_unused_bits = ^{cpc[1:0], ex_pc[1:0]};

  assign w_lk_idx  = cpc[IDX_W+1:2];
  assign w_lk_tag  = cpc[31:IDX_W+2];
  assign w_lk_hit  = r_valid[w_lk_idx] & (r_tag[w_lk_idx] == w_lk_tag);

  assign w_upd_idx = ex_pc[IDX_W+1:2];
  assign w_upd_tag = ex_pc[31:IDX_W+2];
  assign w_upd_hit = r_valid[w_upd_idx] & (r_tag[w_upd_idx] == w_upd_tag);

  // Wrong direction, or right direction but wrong target, is a mispredict
  assign w_flush = ex_br_valid &
                   ((ex_taken != ex_pred_taken) |
                    (ex_taken & ex_pred_taken & (ex_target != ex_pred_target)));
  assign w_nop   = stall_in & ~w_flush;

  assign flush       = w_flush;
  assign pc_branch   = ex_taken ? ex_target : (ex_pc + 32'd4);
  assign control_pc  = r_target[w_lk_idx];
  assign mispred_cnt = r_mispred_cnt;

  // BTB training from EX resolutions; lookups this cycle see old contents
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
    end else if (ex_br_valid) begin
      if (w_upd_hit) begin
        if (ex_taken) begin
          if (r_ctr[w_upd_idx] != 2'b11)
            r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] + 2'b01;
          r_target[w_upd_idx] <= ex_target;
        end else if (r_ctr[w_upd_idx] != 2'b00) begin
          r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] - 2'b01;
        end
      end else if (ex_taken) begin
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= ex_target;
        r_ctr[w_upd_idx]    <= 2'b10;
      end
    end
  end

  // Saturating mispredict counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_mispred_cnt <= '0;
    else if (w_flush && (r_mispred_cnt != 16'hFFFF))
      r_mispred_cnt <= r_mispred_cnt + 16'd1;
  end

  // Halt FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_drain_cnt <= w_drain_cnt_next;
    end
  end

  // Halt FSM next state: a flush while draining means the halt was speculative
  always_comb begin
    w_state_next     = r_state;
    w_drain_cnt_next = r_drain_cnt;
    case (r_state)
      S_RUN: begin
        if (halt_in && !w_flush && !stall_in) begin
          w_state_next     = S_DRAIN;
          w_drain_cnt_next = CNT_W'(DRAIN_CYC - 1);
        end
      end
      S_DRAIN: begin
        if (w_flush)
          w_state_next = S_RUN;
        else if (r_drain_cnt == '0)
          w_state_next = S_HALTED;
        else
          w_drain_cnt_next = r_drain_cnt - 1'b1;
      end
      S_HALTED: w_state_next = S_HALTED;
      default:  w_state_next = S_RUN;
    endcase
  end

  // Fetch command outputs, prioritised flush > halt/stall > prediction
  always_comb begin
    nop         = w_nop;
    prediction  = w_lk_hit & r_ctr[w_lk_idx][1] & ~w_flush & ~w_nop &
                  (r_state == S_RUN);
    halt_happen = (r_state == S_HALTED) | ((r_state == S_DRAIN) & ~w_flush);
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

Next-PC steering controller for the instruction-fetch stage. It owns a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, and from it produces the `prediction`/`control_pc` redirect. It resolves mispredicts reported by EX into `flush`/`pc_branch`, and arbitrates stall, flush and halt so the fetch PC register receives a consistent, prioritised command each cycle. It sits between the hazard unit, the EX branch-resolution logic and the fetch PC register.

## Interface
- `ENTRIES`, 16: BTB entries; power of two, ≥2.
- `IDX_W`, 4: log2(`ENTRIES`).
- `DRAIN_CYC`, 3: cycles from halt detection to the HALTED state.

- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `cpc` in 32: current fetch PC.
- `stall_in` in 1: hazard-unit stall request.
- `halt_in` in 1: ID has decoded a halt instruction.
- `ex_br_valid` in 1: a branch/jump resolves in EX this cycle.
- `ex_pc` in 32: PC of the resolving branch.
- `ex_taken` in 1: actual direction.
- `ex_target` in 32: actual taken target.
- `ex_pred_taken` in 1: prediction carried with the branch.
- `ex_pred_target` in 32: predicted target carried with the branch.
- `prediction` out 1: redirect fetch to `control_pc`.
- `control_pc` out 32: predicted target.
- `flush` out 1: mispredict; load `pc_branch`.
- `pc_branch` out 32: corrected PC.
- `nop` out 1: hold the PC.
- `halt_happen` out 1: freeze fetch.
- `mispred_cnt` out 16: saturating mispredict count.

## Operation
- BTB entry fields: `valid`, `tag` = pc[31:IDX_W+2], `target`[31:0], `ctr`[1:0]. Index = pc[IDX_W+1:2].
- Lookup is combinational on `cpc`. `hit` = valid & tag match. `prediction` = hit & ctr[1] & ~flush & ~nop & (state==RUN). `control_pc` = entry target, driven regardless of `prediction`.
- Mispredict: `flush` = ex_br_valid & ((ex_taken != ex_pred_taken) | (ex_taken & ex_pred_taken & ex_target != ex_pred_target)).
- `pc_branch` = ex_taken ? ex_target : ex_pc+4, with 32-bit wrap.
- `nop` = stall_in & ~flush. Flush overrides stall.
- BTB update on posedge when ex_br_valid, using `ex_pc`:
  - Hit: ctr increments (saturating at 3) if taken, otherwise decrements (saturating at 0). Target is overwritten with ex_target when taken.
  - Miss and taken: allocate/replace with valid=1, tag, target, ctr=2'b10.
  - Miss and not taken: no change.
- If an update and a lookup hit the same index in the same cycle, the lookup sees the old contents.
- Halt FSM:
  - RUN → DRAIN when halt_in & ~flush & ~stall_in. The drain counter is loaded with DRAIN_CYC-1.
  - DRAIN counts down by 1 per cycle; at 0 → HALTED.
  - In DRAIN, a flush cancels the halt (the halt was on the wrong path) → RUN.
  - HALTED is sticky until `rst`.
- `halt_happen` = (state==HALTED) | (state==DRAIN & ~flush).
- `mispred_cnt` increments once per cycle in which `flush`=1 and saturates at 0xFFFF.

## Timing
- All outputs except `mispred_cnt` are combinational from the current inputs and state. The fetch register acts on them at the next posedge.
- Reset state: all `valid`=0, all `ctr`=2'b01, state=RUN, `mispred_cnt`=0.
- Consequently, under reset with quiet inputs: `prediction`=0, `flush`=0, `nop`=0, `halt_happen`=0, `control_pc`=0 (target regs cleared). `pc_branch` is driven from `ex_pc`+4, i.e. 4 when inputs are 0.
- Priority presented to fetch: flush > halt/stall > prediction > sequential. Consequently `prediction`, `nop` and `halt_happen` are never 1 in a cycle where `flush`=1, except `halt_happen` in HALTED.
- BTB learning latency: a branch resolved at edge N is predicted for lookups from N+1 onward.
- A 2-bit counter needs two consecutive not-taken resolutions to go from 3 to 1.
- `rst` asserted mid-DRAIN returns to RUN immediately and clears the BTB.

## Test plan
- Reset → `prediction`=0, `nop`=0, `halt_happen`=0, `mispred_cnt`=0. With cpc=0x40, `prediction` stays 0.
- Taken branch, first encounter: ex_br_valid, ex_pc=0x40, ex_taken=1, ex_target=0x100, ex_pred_taken=0.
  - Same cycle: `flush`=1, `pc_branch`=0x100.
  - Next cycle with cpc=0x40: `prediction`=1, `control_pc`=0x100.
- Counter hysteresis, entry at ctr=3:
  - One not-taken resolve (pred=1) → `flush`=1, `pc_branch`=0x44; cpc=0x40 still predicts taken (ctr=2).
  - Second not-taken → ctr=1, `prediction`=0.
- Stall and flush together: stall_in=1 while a mispredict resolves → `nop`=0, `flush`=1.
  - Next cycle, flush gone, stall_in=1 → `nop`=1.
- Halt: halt_in pulse in RUN → `halt_happen`=1 next cycle, state HALTED after 3 cycles, sticky.
  - Repeat with a mispredict on the 2nd DRAIN cycle → `halt_happen`=0 that cycle, state RUN afterwards.
- Target mismatch with correct direction: pred taken to 0x200, actual taken to 0x300 → `flush`=1, `pc_branch`=0x300.
  - `mispred_cnt` increments by 1; the BTB target for that entry becomes 0x300.
